qos_channel_selector: RTL and testbench

//  Decision engine of the QoS core: selects which of 4 MPEG2-TS input channels drives the output.

---
 rtl/qos_pkg.sv | 28 ++
 rtl/qos_channel_rank.sv | 54 +++++
 rtl/qos_channel_selector.sv | 196 +++++++++++++++++++
 tb/tb_qos_channel_selector.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qos_pkg.sv
// Shared types and defaults for the QoS channel selector.
//   chan_t       : 2-bit channel index (4 TS input channels)
//   rank_t       : 3-bit priority rank, RANK_NONE for channels absent from the list
//   sel_state_t  : selector FSM state, read back as sel_state
//   prio_slot()  : extract the channel held in one slot of the priority list
package qos_pkg;

    typedef logic [1:0] chan_t;
    typedef logic [2:0] rank_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_HOLD   = 2'd3
    } sel_state_t;

    localparam logic [7:0] ERR_THRESHOLD_DEF = 8'd16;
    localparam logic [7:0] DEF_PRIORITY_DEF  = 8'hE4;
    localparam int         SW_CNT_W_DEF      = 16;
    localparam int         HOLD_W            = 20;
    localparam rank_t      RANK_NONE         = 3'd4;

    function automatic chan_t prio_slot(input logic [7:0] prio, input int slot);
        return prio[2*slot +: 2];
    endfunction

endpackage

// File: rtl/qos_channel_rank.sv
// Combinational health and priority evaluation for the 4 input channels.
// Ports:
//   i_priority          8  shadow priority list, slot k = bits[2k+1:2k], slot 0 highest
//   i_signal_present    4  per-channel sync/lock
//   i_error_count_ch0..3 8 per-channel error counts
//   o_ok                4  channel healthy (present and below error threshold)
//   o_rank           4x3  lowest slot holding each channel, RANK_NONE if absent
//   o_best              2  healthy channel in the lowest slot
//   o_none_ok           1  no slot of the list holds a healthy channel
module qos_channel_rank
    import qos_pkg::*;
#(
    parameter logic [7:0] ERR_THRESHOLD = ERR_THRESHOLD_DEF
) (
    input  logic [7:0]  i_priority,
    input  logic [3:0]  i_signal_present,
    input  logic [7:0]  i_error_count_ch0,
    input  logic [7:0]  i_error_count_ch1,
    input  logic [7:0]  i_error_count_ch2,
    input  logic [7:0]  i_error_count_ch3,
    output logic [3:0]  o_ok,
    output rank_t [3:0] o_rank,
    output chan_t       o_best,
    output logic        o_none_ok
);

    logic [3:0][7:0] w_err;

    assign w_err = {i_error_count_ch3, i_error_count_ch2, i_error_count_ch1, i_error_count_ch0};

    always_comb begin
        o_ok = '0;
        for (int ch = 0; ch < 4; ch++) begin
            o_ok[ch] = i_signal_present[ch] && (w_err[ch] < ERR_THRESHOLD);
        end
    end

    // Slots are walked from lowest to highest priority so that the earliest
    // slot overwrites later ones: a duplicated channel takes its first rank,
    // and the last healthy hit is the best one.
    always_comb begin
        o_rank    = {4{RANK_NONE}};
        o_best    = '0;
        o_none_ok = 1'b1;
        for (int slot = 3; slot >= 0; slot--) begin
            o_rank[prio_slot(i_priority, slot)] = rank_t'(slot);
            if (o_ok[prio_slot(i_priority, slot)]) begin
                o_best    = prio_slot(i_priority, slot);
                o_none_ok = 1'b0;
            end
        end
    end

endmodule

// File: rtl/qos_channel_selector.sv
// Decision engine of the QoS core: picks which of 4 MPEG2-TS inputs drives the output.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   valid_config           1-cycle pulse, latch fallback_enable/channel_priority/reset_timer
//   fallback_enable        allow automatic switch away from a failed channel
//   manual_enable          live: pin output to manual_channel
//   manual_channel    2    channel used in manual mode (live)
//   channel_priority  8    priority list, slot 0 highest
//   reset_timer      20    revert hold-off in cycles
//   signal_present    4    per-channel sync/lock
//   error_count_ch0..3 8   per-channel error counts
//   active_channel    2    selected channel (registered)
//   output_valid      1    selected channel healthy (registered)
//   switch_pulse      1    high the cycle active_channel takes a new value
//   switch_count      SW_CNT_W saturating number of switches since reset
//   sel_state         2    FSM state readback
//
// State      | meaning
// -----------+----------------------------------------------------------
// IDLE   (0) | no healthy channel selected, waiting for one to appear
// MANUAL (1) | output pinned to manual_channel
// ACTIVE (2) | automatic selection, current channel kept while healthy
// HOLD   (3) | better channel available, counting down before reverting
module qos_channel_selector
    import qos_pkg::*;
#(
    parameter logic [7:0] ERR_THRESHOLD = ERR_THRESHOLD_DEF,
    parameter logic [7:0] DEF_PRIORITY  = DEF_PRIORITY_DEF,
    parameter int         SW_CNT_W      = SW_CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_config,
    input  logic                fallback_enable,
    input  logic                manual_enable,
    input  logic [1:0]          manual_channel,
    input  logic [7:0]          channel_priority,
    input  logic [HOLD_W-1:0]   reset_timer,
    input  logic [3:0]          signal_present,
    input  logic [7:0]          error_count_ch0,
    input  logic [7:0]          error_count_ch1,
    input  logic [7:0]          error_count_ch2,
    input  logic [7:0]          error_count_ch3,
    output logic [1:0]          active_channel,
    output logic                output_valid,
    output logic                switch_pulse,
    output logic [SW_CNT_W-1:0] switch_count,
    output logic [1:0]          sel_state
);

    localparam logic [HOLD_W-1:0]   HOLD_ONE = {{(HOLD_W-1){1'b0}}, 1'b1};
    localparam logic [SW_CNT_W-1:0] CNT_ONE  = {{(SW_CNT_W-1){1'b0}}, 1'b1};

    // shadow configuration
    logic              r_fallback;
    logic [7:0]        r_prio;
    logic [HOLD_W-1:0] r_timer;

    // FSM and status registers
    sel_state_t          r_state;
    chan_t               r_active;
    logic                r_valid;
    logic                r_pulse;
    logic [SW_CNT_W-1:0] r_count;
    logic [HOLD_W-1:0]   r_hold;

    logic [3:0]        w_ok;
    rank_t [3:0]       w_rank;
    chan_t             w_best;
    logic              w_none_ok;
    logic              w_cur_ok;
    logic              w_better;
    sel_state_t        w_nxt_state;
    chan_t             w_nxt_active;
    logic              w_nxt_valid;
    logic [HOLD_W-1:0] w_nxt_hold;
    logic              w_switch;

    qos_channel_rank #(
        .ERR_THRESHOLD (ERR_THRESHOLD)
    ) u_rank (
        .i_priority        (r_prio),
        .i_signal_present  (signal_present),
        .i_error_count_ch0 (error_count_ch0),
        .i_error_count_ch1 (error_count_ch1),
        .i_error_count_ch2 (error_count_ch2),
        .i_error_count_ch3 (error_count_ch3),
        .o_ok              (w_ok),
        .o_rank            (w_rank),
        .o_best            (w_best),
        .o_none_ok         (w_none_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fallback <= 1'b0;
            r_prio     <= DEF_PRIORITY;
            r_timer    <= '0;
        end else if (valid_config) begin
            r_fallback <= fallback_enable;
            r_prio     <= channel_priority;
            r_timer    <= reset_timer;
        end
    end

    assign w_cur_ok = w_ok[r_active];
    // w_best is meaningless when nothing in the list is healthy, so never call it better.
    assign w_better = !w_none_ok && (w_rank[w_best] < w_rank[r_active]);

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_active = r_active;
        w_nxt_valid  = r_valid;
        w_nxt_hold   = r_hold;
        if (manual_enable) begin
            w_nxt_state  = ST_MANUAL;
            w_nxt_active = manual_channel;
            w_nxt_valid  = w_ok[manual_channel];
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_nxt_valid = 1'b0;
                    if (!w_none_ok) begin
                        w_nxt_state  = ST_ACTIVE;
                        w_nxt_active = w_best;
                        w_nxt_valid  = 1'b1;
                    end
                end
                ST_MANUAL: begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_valid = 1'b0;
                end
                default: begin
                    // ACTIVE and HOLD share the failure handling; HOLD always
                    // leaves unless the countdown continues below.
                    w_nxt_state = ST_ACTIVE;
                    w_nxt_valid = w_cur_ok;
                    if (!w_cur_ok) begin
                        if (w_none_ok) begin
                            w_nxt_state = ST_IDLE;
                            w_nxt_valid = 1'b0;
                        end else if (r_fallback) begin
                            w_nxt_active = w_best;
                            w_nxt_valid  = 1'b1;
                        end
                    end else if (r_state == ST_ACTIVE) begin
                        if (w_better) begin
                            if (r_timer == '0) begin
                                w_nxt_active = w_best;
                            end else begin
                                w_nxt_state = ST_HOLD;
                                w_nxt_hold  = r_timer - HOLD_ONE;
                            end
                        end
                    end else if (!valid_config && w_better) begin
                        if (r_hold == '0) begin
                            w_nxt_active = w_best;
                        end else begin
                            w_nxt_state = ST_HOLD;
                            w_nxt_hold  = r_hold - HOLD_ONE;
                        end
                    end
                end
            endcase
        end
    end

    assign w_switch = (w_nxt_active != r_active);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_active <= '0;
            r_valid  <= 1'b0;
            r_pulse  <= 1'b0;
            r_count  <= '0;
            r_hold   <= '0;
        end else begin
            r_state  <= w_nxt_state;
            r_active <= w_nxt_active;
            r_valid  <= w_nxt_valid;
            r_hold   <= w_nxt_hold;
            r_pulse  <= w_switch;
            if (w_switch && (r_count != '1)) begin
                r_count <= r_count + CNT_ONE;
            end
        end
    end

    assign active_channel = r_active;
    assign output_valid   = r_valid;
    assign switch_pulse   = r_pulse;
    assign switch_count   = r_count;
    assign sel_state      = r_state;

endmodule

// File: tb/tb_qos_channel_selector.sv
`timescale 1ns/1ps
module tb_qos_channel_selector;

    // Narrow switch counter so saturation is reached within the run.
    localparam int SW_W    = 4;
    localparam int CNT_MAX = (1 << SW_W) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            valid_config;
    logic            fallback_enable;
    logic            manual_enable;
    logic [1:0]      manual_channel;
    logic [7:0]      channel_priority;
    logic [19:0]     reset_timer;
    logic [3:0]      signal_present;
    logic [7:0]      error_count_ch0;
    logic [7:0]      error_count_ch1;
    logic [7:0]      error_count_ch2;
    logic [7:0]      error_count_ch3;
    logic [1:0]      active_channel;
    logic            output_valid;
    logic            switch_pulse;
    logic [SW_W-1:0] switch_count;
    logic [1:0]      sel_state;

    always #5 clk = ~clk;

    qos_channel_selector #(
        .SW_CNT_W (SW_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .valid_config     (valid_config),
        .fallback_enable  (fallback_enable),
        .manual_enable    (manual_enable),
        .manual_channel   (manual_channel),
        .channel_priority (channel_priority),
        .reset_timer      (reset_timer),
        .signal_present   (signal_present),
        .error_count_ch0  (error_count_ch0),
        .error_count_ch1  (error_count_ch1),
        .error_count_ch2  (error_count_ch2),
        .error_count_ch3  (error_count_ch3),
        .active_channel   (active_channel),
        .output_valid     (output_valid),
        .switch_pulse     (switch_pulse),
        .switch_count     (switch_count),
        .sel_state        (sel_state)
    );

    typedef struct {
        logic        vc;
        logic        fb;
        logic        men;
        logic [1:0]  mch;
        logic [7:0]  prio;
        logic [19:0] tmr;
        logic [3:0]  sp;
        logic [7:0]  e0;
        int          x_act;
        int          x_val;
        int          x_pls;
        int          x_cnt;
        int          x_st;
    } vec_t;

    vec_t tv[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(input int vc, input int fb, input int men, input int mch,
                                input int prio, input int tmr, input int sp, input int e0,
                                input int act, input int val, input int pls, input int cnt,
                                input int st);
        vec_t v;
        v.vc    = 1'(vc);
        v.fb    = 1'(fb);
        v.men   = 1'(men);
        v.mch   = 2'(mch);
        v.prio  = 8'(prio);
        v.tmr   = 20'(tmr);
        v.sp    = 4'(sp);
        v.e0    = 8'(e0);
        v.x_act = act;
        v.x_val = val;
        v.x_pls = pls;
        v.x_cnt = (cnt > CNT_MAX) ? CNT_MAX : cnt;
        v.x_st  = st;
        return v;
    endfunction

    task automatic chk(input string what, input int idx, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0d exp=%0d", what, idx, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input int idx, input int act, input int val,
                             input int pls, input int cnt, input int st);
        chk({tag, ".active"}, idx, int'(active_channel), act);
        chk({tag, ".valid"},  idx, int'(output_valid),   val);
        chk({tag, ".pulse"},  idx, int'(switch_pulse),   pls);
        chk({tag, ".count"},  idx, int'(switch_count),   cnt);
        chk({tag, ".state"},  idx, int'(sel_state),      st);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            valid_config     = tv[i].vc;
            fallback_enable  = tv[i].fb;
            manual_enable    = tv[i].men;
            manual_channel   = tv[i].mch;
            channel_priority = tv[i].prio;
            reset_timer      = tv[i].tmr;
            signal_present   = tv[i].sp;
            error_count_ch0  = tv[i].e0;
            step();
            check_out("vec", i, tv[i].x_act, tv[i].x_val, tv[i].x_pls, tv[i].x_cnt, tv[i].x_st);
        end
    endtask

    initial begin
        int n;
        //                vc fb me mc prio   tmr  sp    e0    act val pls cnt st
        // power-up selection and fallback / immediate revert
        tv.push_back(mk(0, 0, 0, 0, 8'hE4, 0,   4'hF, 0,    0, 1, 0, 0,  2)); // 0
        tv.push_back(mk(0, 0, 0, 0, 8'hE4, 0,   4'hF, 0,    0, 1, 0, 0,  2)); // 1
        tv.push_back(mk(1, 1, 0, 0, 8'hE4, 0,   4'hF, 0,    0, 1, 0, 0,  2)); // 2
        tv.push_back(mk(0, 1, 0, 0, 8'hE4, 0,   4'hF, 16,   1, 1, 1, 1,  2)); // 3
        tv.push_back(mk(0, 1, 0, 0, 8'hE4, 0,   4'hF, 15,   0, 1, 1, 2,  2)); // 4
        tv.push_back(mk(0, 1, 0, 0, 8'hE4, 0,   4'hF, 16,   1, 1, 1, 3,  2)); // 5
        tv.push_back(mk(0, 1, 0, 0, 8'hE4, 0,   4'hF, 16,   1, 1, 0, 3,  2)); // 6
        tv.push_back(mk(1, 1, 0, 0, 8'hE4, 100, 4'hF, 16,   1, 1, 0, 3,  2)); // 7
        // no fallback, total loss, recovery
        tv.push_back(mk(1, 0, 0, 0, 8'hE4, 0,   4'hF, 16,   1, 1, 0, 5,  2)); // 8
        tv.push_back(mk(0, 0, 0, 0, 8'hE4, 0,   4'hF, 0,    0, 1, 1, 6,  2)); // 9
        tv.push_back(mk(0, 0, 0, 0, 8'hE4, 0,   4'hE, 0,    0, 0, 0, 6,  2)); // 10
        tv.push_back(mk(0, 0, 0, 0, 8'hE4, 0,   4'h0, 0,    0, 0, 0, 6,  0)); // 11
        tv.push_back(mk(0, 0, 0, 0, 8'hE4, 0,   4'h0, 0,    0, 0, 0, 6,  0)); // 12
        tv.push_back(mk(0, 0, 0, 0, 8'hE4, 0,   4'h4, 0,    2, 1, 1, 7,  2)); // 13
        tv.push_back(mk(0, 0, 0, 0, 8'hE4, 0,   4'hF, 0,    0, 1, 1, 8,  2)); // 14
        // manual override from HOLD
        tv.push_back(mk(1, 1, 0, 0, 8'hE4, 20,  4'hF, 0,    0, 1, 0, 8,  2)); // 15
        tv.push_back(mk(0, 1, 0, 0, 8'hE4, 20,  4'hF, 16,   1, 1, 1, 9,  2)); // 16
        tv.push_back(mk(0, 1, 0, 0, 8'hE4, 20,  4'hF, 0,    1, 1, 0, 9,  3)); // 17
        tv.push_back(mk(0, 1, 1, 3, 8'hE4, 20,  4'hF, 0,    3, 1, 1, 10, 1)); // 18
        tv.push_back(mk(0, 1, 1, 2, 8'hE4, 20,  4'hB, 0,    2, 0, 1, 11, 1)); // 19
        tv.push_back(mk(0, 1, 1, 2, 8'hE4, 20,  4'hF, 0,    2, 1, 0, 11, 1)); // 20
        tv.push_back(mk(0, 1, 0, 2, 8'hE4, 20,  4'hF, 0,    2, 0, 0, 11, 0)); // 21
        tv.push_back(mk(0, 1, 0, 2, 8'hE4, 20,  4'hF, 0,    0, 1, 1, 12, 2)); // 22
        // valid_config during HOLD restarts the revert with the new timer
        tv.push_back(mk(0, 1, 0, 0, 8'hE4, 20,  4'hF, 16,   1, 1, 1, 13, 2)); // 23
        tv.push_back(mk(0, 1, 0, 0, 8'hE4, 20,  4'hF, 0,    1, 1, 0, 13, 3)); // 24
        tv.push_back(mk(1, 1, 0, 0, 8'hE4, 3,   4'hF, 0,    1, 1, 0, 13, 2)); // 25
        tv.push_back(mk(0, 1, 0, 0, 8'hE4, 3,   4'hF, 0,    1, 1, 0, 13, 3)); // 26
        tv.push_back(mk(0, 1, 0, 0, 8'hE4, 3,   4'hF, 0,    1, 1, 0, 13, 3)); // 27
        tv.push_back(mk(0, 1, 0, 0, 8'hE4, 3,   4'hF, 0,    1, 1, 0, 13, 3)); // 28
        tv.push_back(mk(0, 1, 0, 0, 8'hE4, 3,   4'hF, 0,    0, 1, 1, 14, 2)); // 29
        // reversed list, duplicated slots, absent channel, counter saturation
        tv.push_back(mk(1, 1, 0, 0, 8'h1B, 0,   4'hF, 0,    0, 1, 0, 14, 2)); // 30
        tv.push_back(mk(0, 1, 0, 0, 8'h1B, 0,   4'hF, 0,    3, 1, 1, 15, 2)); // 31
        tv.push_back(mk(1, 1, 0, 0, 8'h1F, 0,   4'hF, 0,    3, 1, 0, 15, 2)); // 32
        tv.push_back(mk(0, 1, 0, 0, 8'h1F, 0,   4'h7, 0,    1, 1, 1, 16, 2)); // 33
        tv.push_back(mk(0, 1, 0, 0, 8'h1F, 0,   4'h4, 0,    1, 0, 0, 16, 0)); // 34
        tv.push_back(mk(0, 1, 0, 0, 8'h1F, 0,   4'hF, 0,    3, 1, 1, 17, 2)); // 35
        tv.push_back(mk(1, 1, 0, 0, 8'h1F, 50,  4'hF, 0,    3, 1, 0, 17, 2)); // 36
        tv.push_back(mk(0, 1, 0, 0, 8'h1F, 50,  4'h7, 0,    1, 1, 1, 18, 2)); // 37
        tv.push_back(mk(0, 1, 0, 0, 8'h1F, 50,  4'hF, 0,    1, 1, 0, 18, 3)); // 38
        tv.push_back(mk(0, 1, 0, 0, 8'h1F, 50,  4'hF, 0,    1, 1, 0, 18, 3)); // 39

        rst_n            = 1'b0;
        valid_config     = 1'b0;
        fallback_enable  = 1'b0;
        manual_enable    = 1'b0;
        manual_channel   = 2'd0;
        channel_priority = 8'hE4;
        reset_timer      = 20'd0;
        signal_present   = 4'hF;
        error_count_ch0  = 8'd0;
        error_count_ch1  = 8'd0;
        error_count_ch2  = 8'd0;
        error_count_ch3  = 8'd0;

        #2;
        check_out("reset", 0, 0, 0, 0, 0, 0);
        step();
        step();
        check_out("reset", 1, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        run_vecs(0, 7);

        // revert to ch0 exactly 100 cycles after it recovers
        valid_config    = 1'b0;
        error_count_ch0 = 8'd0;
        step();
        check_out("hold_enter", 0, 1, 1, 0, 3, 3);
        n = 0;
        for (int i = 2; i <= 100; i++) begin
            step();
            if (active_channel == 2'd1 && sel_state == 2'd3) n++;
        end
        chk("hold_len", 0, n, 99);
        step();
        check_out("revert", 0, 0, 1, 1, 4, 2);

        // better channel lost at cycle 50 of the hold: no switch
        error_count_ch0 = 8'd16;
        step();
        check_out("drop_fb", 0, 1, 1, 1, 5, 2);
        error_count_ch0 = 8'd0;
        step();
        check_out("hold_enter", 1, 1, 1, 0, 5, 3);
        n = 0;
        for (int i = 2; i <= 49; i++) begin
            step();
            if (active_channel == 2'd1 && sel_state == 2'd3) n++;
        end
        chk("hold_len", 1, n, 48);
        error_count_ch0 = 8'd16;
        step();
        check_out("better_lost", 0, 1, 1, 0, 5, 2);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (active_channel == 2'd1 && sel_state == 2'd2) n++;
        end
        chk("stay_ch1", 0, n, 60);

        run_vecs(8, 39);

        // asynchronous reset in the middle of HOLD
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 0, 0, 0, 0, 0, 0);
        step();
        check_out("async_rst", 1, 0, 0, 0, 0, 0);
        valid_config    = 1'b0;
        manual_enable   = 1'b0;
        signal_present  = 4'hF;
        error_count_ch0 = 8'd0;
        rst_n           = 1'b1;
        // shadow list is back to the default order, so ch0 wins despite the 8'h1F on the bus
        step();
        check_out("post_rst", 0, 0, 1, 0, 0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
